// File: rtl/pdm_cic_decimator.sv
// PDM->PCM Hogenauer CIC decimator (N stages, R=2^LOG2R, M=1). Latency: strobe edge -> registered pcm_out.
// No backpressure: ce=0 freezes all state and drives pcm_valid low; pcm_valid is a one-cycle strobe.
module pdm_cic_decimator #(
  parameter int N     = 4,
  parameter int LOG2R = 6,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic             pdm_in,
  output logic [OUT_W-1:0] pcm_out,
  output logic             pcm_valid
);

  localparam int ACC_W = N * LOG2R + 2;
  localparam int SHIFT = N * LOG2R - (OUT_W - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [ACC_W-1:0] integ_q [N];
  logic signed [ACC_W-1:0] integ_d [N];
  logic signed [ACC_W-1:0] dly_q   [N];
  logic signed [ACC_W-1:0] dly_d   [N];
  logic signed [ACC_W-1:0] comb_c  [N+1];
  logic [LOG2R-1:0]        cnt_q, cnt_d;
  logic [OUT_W-1:0]        pcm_out_q, pcm_out_d;
  logic                    pcm_valid_q, pcm_valid_d;
  logic signed [ACC_W-1:0] x;
  logic signed [ACC_W-1:0] scaled;
  logic                    strobe;

  always_comb begin
    x      = pdm_in ? {{(ACC_W-1){1'b0}}, 1'b1} : {ACC_W{1'b1}};
    strobe = ce && (cnt_q == {LOG2R{1'b1}});

    // Comb chain is evaluated combinationally from the pre-update integrator output.
    comb_c[0] = integ_q[N-1];
    for (int k = 1; k <= N; k++) begin
      comb_c[k] = comb_c[k-1] - dly_q[k-1];
    end
    scaled = comb_c[N] >>> SHIFT;

    integ_d     = integ_q;
    dly_d       = dly_q;
    cnt_d       = cnt_q;
    pcm_out_d   = pcm_out_q;
    pcm_valid_d = 1'b0;

    if (ce) begin
      integ_d[0] = integ_q[0] + x;
      for (int k = 1; k < N; k++) begin
        integ_d[k] = integ_q[k] + integ_q[k-1];
      end
      cnt_d = cnt_q + LOG2R'(1);
    end

    if (strobe) begin
      for (int k = 0; k < N; k++) begin
        dly_d[k] = comb_c[k];
      end
      pcm_valid_d = 1'b1;
      if (scaled > SAT_MAX) begin
        pcm_out_d = SAT_MAX[OUT_W-1:0];
      end else if (scaled < SAT_MIN) begin
        pcm_out_d = SAT_MIN[OUT_W-1:0];
      end else begin
        pcm_out_d = scaled[OUT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      integ_q     <= '{default: '0};
      dly_q       <= '{default: '0};
      cnt_q       <= '0;
      pcm_out_q   <= '0;
      pcm_valid_q <= 1'b0;
    end else begin
      integ_q     <= integ_d;
      dly_q       <= dly_d;
      cnt_q       <= cnt_d;
      pcm_out_q   <= pcm_out_d;
      pcm_valid_q <= pcm_valid_d;
    end
  end

  assign pcm_out   = pcm_out_q;
  assign pcm_valid = pcm_valid_q;

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Bench for pdm_cic_decimator: reference is the equivalent FIR (boxcar^N) on the consumed PDM bits,
// evaluated every R-th ce edge, then shifted and clamped.
module tb_pdm_cic_decimator;

  localparam int N      = 4;
  localparam int LOG2R  = 6;
  localparam int OUT_W  = 16;
  localparam int R      = 1 << LOG2R;
  localparam int HL     = N * (R - 1) + 1;
  localparam int SH     = N * LOG2R - (OUT_W - 1);
  localparam int SINE_L = 16384;

  logic             clk = 1'b0;
  logic             reset;
  logic             ce;
  logic             pdm_in;
  logic [OUT_W-1:0] pcm_out;
  logic             pcm_valid;

  always #5 clk = ~clk;

  pdm_cic_decimator #(.N(N), .LOG2R(LOG2R), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .pdm_in    (pdm_in),
    .pcm_out   (pcm_out),
    .pcm_valid (pcm_valid)
  );

  int               tests = 0;
  int               fails = 0;
  longint           h [HL];
  int               xs [$];
  int               ce_edges = 0;
  logic             exp_vld = 1'b0;
  logic [OUT_W-1:0] exp_out = '0;
  bit               armed = 1'b0;
  bit               rec = 1'b0;
  logic [OUT_W-1:0] rec_q [$];
  logic [OUT_W-1:0] seq4 [$];
  int               vld_seen = 0;
  int               first_vld_edge = -1;
  bit               sine_bits [SINE_L];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Boxcar^N FIR applied to the ce-consumed bit history; the pipelined integrators add N bits of delay.
  function automatic logic [OUT_W-1:0] model_out(input int t);
    longint acc;
    longint maxv;
    int     idx;
    acc  = 0;
    maxv = (longint'(1) <<< (OUT_W - 1)) - 1;
    for (int j = 0; j < HL; j++) begin
      idx = t - N - j;
      if (idx >= 1) acc += h[j] * longint'(xs[idx-1]);
    end
    acc = acc >>> SH;
    if (acc > maxv) acc = maxv;
    if (acc < -maxv - 1) acc = -maxv - 1;
    return acc[OUT_W-1:0];
  endfunction

  task automatic step(input bit c, input bit b, input bit r);
    ce     = c;
    pdm_in = b;
    reset  = r;
    @(posedge clk);
    #1;
    if (r) begin
      xs.delete();
      ce_edges = 0;
      exp_vld  = 1'b0;
      exp_out  = '0;
      armed    = 1'b1;
    end else if (c) begin
      xs.push_back(b ? 1 : -1);
      ce_edges++;
      exp_vld = (ce_edges % R == 0);
      if (exp_vld) exp_out = model_out(ce_edges);
    end else begin
      exp_vld = 1'b0;
    end
    if (armed) check("valid_and_pcm", 64'({pcm_valid, pcm_out}), 64'({exp_vld, exp_out}));
    if (armed && pcm_valid === 1'b1) begin
      vld_seen++;
      if (rec) rec_q.push_back(pcm_out);
      if (first_vld_edge < 0) first_vld_edge = ce_edges;
    end
  endtask

  function automatic bit pat_bit(input int kind, input int i);
    case (kind)
      0:       return 1'b1;
      1:       return 1'b0;
      2:       return (i % 2 == 0);
      3:       return (i % 4 != 3);
      4:       return sine_bits[i % SINE_L];
      default: return 1'($urandom_range(1));
    endcase
  endfunction

  task automatic run(input int kind, input int n_out, input int ce_pct);
    bit c;
    step(1'b1, 1'b0, 1'b1);
    vld_seen       = 0;
    first_vld_edge = -1;
    for (int cyc = 0; cyc < n_out * R * 8 + 100 && vld_seen < n_out; cyc++) begin
      c = (ce_pct >= 100) ? 1'b1 : ($urandom_range(99) < ce_pct);
      step(c, c ? pat_bit(kind, ce_edges) : 1'($urandom_range(1)), 1'b0);
    end
    if (vld_seen < n_out) check("output_count_timeout", 64'(vld_seen), 64'(n_out));
  endtask

  initial begin
    longint poly [HL];
    longint nxt  [HL];
    real    v;
    real    u;
    bit     y;
    bit     c;
    int     plen;

    reset  = 1'b1;
    ce     = 1'b0;
    pdm_in = 1'b0;

    for (int i = 0; i < HL; i++) poly[i] = 0;
    poly[0] = 1;
    plen    = 1;
    for (int s = 0; s < N; s++) begin
      for (int i = 0; i < HL; i++) begin
        nxt[i] = 0;
        for (int k = 0; k < R; k++) if (i - k >= 0 && i - k < plen) nxt[i] += poly[i-k];
      end
      plen += R - 1;
      poly = nxt;
    end
    h = poly;

    v = 0.0;
    for (int i = 0; i < SINE_L; i++) begin
      u = 0.5 * $sin(2.0 * 3.14159265358979 * real'(i) / 3072.0);
      y = (v >= 0.0);
      sine_bits[i] = y;
      v = v + u - (y ? 1.0 : -1.0);
    end

    // All ones: first strobe on the 64th ce edge, settles at the positive clamp.
    run(0, 20, 100);
    check("first_valid_edge_ones", 64'(first_vld_edge), 64'(R));
    check("settled_ones_dut", 64'(pcm_out), 64'(16'h7fff));
    check("settled_ones_model", 64'(exp_out), 64'(16'h7fff));

    run(1, 10, 100);
    check("settled_zeros_dut", 64'(pcm_out), 64'(16'h8000));
    check("settled_zeros_model", 64'(exp_out), 64'(16'h8000));

    run(2, 10, 100);
    check("settled_alt_dut", 64'(pcm_out), 64'(16'h0000));
    check("settled_alt_model", 64'(exp_out), 64'(16'h0000));

    run(3, 10, 100);
    check("settled_1110_dut", 64'(pcm_out), 64'(16'h4000));
    check("settled_1110_model", 64'(exp_out), 64'(16'h4000));

    run(5, 40, 100);
    run(5, 30, 50);
    check("first_valid_edge_gated", 64'(first_vld_edge), 64'(R));

    // Sine stream with full ce, then the same stream with gated ce must give the same samples.
    rec_q.delete();
    rec = 1'b1;
    run(4, SINE_L / R, 100);
    seq4 = rec_q;
    rec_q.delete();
    run(4, SINE_L / R, 50);
    rec = 1'b0;
    check("gated_seq_len", 64'(rec_q.size()), 64'(seq4.size()));
    for (int i = 0; i < seq4.size() && i < rec_q.size(); i++) check("gated_seq_sample", 64'(rec_q[i]), 64'(seq4[i]));

    // Mid-stream reset at cnt=30, issued with ce high to exercise reset priority.
    run(5, 3, 70);
    for (int cyc = 0; cyc < 400 && ce_edges % R != 30; cyc++) begin
      c = ($urandom_range(99) < 70);
      step(c, 1'($urandom_range(1)), 1'b0);
    end
    check("pre_reset_cnt", 64'(ce_edges % R), 64'(30));
    step(1'b1, 1'b1, 1'b1);
    check("reset_pcm_out", 64'(pcm_out), 64'(0));
    check("reset_pcm_valid", 64'(pcm_valid), 64'(0));
    vld_seen       = 0;
    first_vld_edge = -1;
    for (int cyc = 0; cyc < 400 && vld_seen == 0; cyc++) begin
      c = ($urandom_range(99) < 70);
      step(c, 1'($urandom_range(1)), 1'b0);
    end
    check("post_reset_first_valid_edge", 64'(first_vld_edge), 64'(R));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
